data_mem_arbiter: RTL and testbench

Shares the single-port data memory between the pipeline MEM stage (CPU port) and a word-burst DMA engine used for program/data loading and memory dumps. The CPU has priority. A starvation counter guarantees the DMA forward progress by stalling the pipeline for one cycle when the DMA has been denied too long. The block sits between the MEM stage and the data memory; the memory-side ports drive the memory's memRead/memWrite/address/writeData and take its combinational readData.

---
 rtl/data_mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - CPU/DMA arbiter for the single-port data memory
// CPU wins by default; a starvation counter forces one DMA grant after STARVE_LIMIT denials.
module data_mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int LEN_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpuRead,
  input  logic             cpuWrite,
  input  logic [31:0]      cpuAddress,
  input  logic [31:0]      cpuWriteData,
  output logic [31:0]      cpuReadData,
  output logic             cpuStall,
  input  logic             dmaStart,
  input  logic             dmaDir,
  input  logic [31:0]      dmaBase,
  input  logic [LEN_W-1:0] dmaLen,
  input  logic [31:0]      dmaInData,
  input  logic             dmaInValid,
  output logic             dmaInReady,
  output logic [31:0]      dmaOutData,
  output logic             dmaOutValid,
  output logic             dmaBusy,
  output logic             dmaDone,
  output logic             memRead,
  output logic             memWrite,
  output logic [31:0]      memAddress,
  output logic [31:0]      memWriteData,
  input  logic [31:0]      memReadData
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [3:0]       LIMIT = 4'(STARVE_LIMIT);
  localparam logic [LEN_W-1:0] ONE   = LEN_W'(1);

  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic [31:0]      base_q, base_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [3:0]       starve_q, starve_d;
  logic [31:0]      out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;

  logic             cpu_req;
  logic             dma_want;
  logic             cpu_first;
  logic             dma_gnt;
  logic             last_word;
  logic [31:0]      dma_addr;

  always_comb begin
    cpu_req   = cpuRead | cpuWrite;
    dma_want  = (state_q == S_BURST) && (!dir_q || dmaInValid);
    cpu_first = cpu_req && (starve_q < LIMIT);
    dma_gnt   = dma_want && !cpu_first;
    last_word = (cnt_q == (len_q - ONE));
    dma_addr  = base_q + 32'(cnt_q);
  end

  // Memory port mux: every granted DMA cycle is a transferred word.
  always_comb begin
    memRead      = cpuRead;
    memWrite     = cpuWrite;
    memAddress   = cpuAddress;
    memWriteData = cpuWriteData;
    if (dma_gnt) begin
      memRead      = !dir_q;
      memWrite     = dir_q;
      memAddress   = dma_addr;
      memWriteData = dmaInData;
    end
  end

  always_comb begin
    cpuReadData = memReadData;
    cpuStall    = cpu_req && dma_gnt;
    dmaInReady  = dma_gnt && dir_q;
    dmaOutData  = out_data_q;
    dmaOutValid = out_valid_q;
    dmaBusy     = (state_q != S_IDLE);
    dmaDone     = (state_q == S_DONE);
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    base_d  = base_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (dmaStart) begin
          dir_d   = dmaDir;
          base_d  = dmaBase;
          len_d   = dmaLen;
          cnt_d   = '0;
          state_d = (dmaLen == '0) ? S_DONE : S_BURST;
        end
      end
      S_BURST: begin
        if (dma_gnt) begin
          cnt_d = cnt_q + ONE;
          if (last_word) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (state_q == S_IDLE) begin
      starve_d = '0;
    end else if (dma_gnt) begin
      starve_d = '0;
    end else if (dma_want && (starve_q < LIMIT)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_comb begin
    out_valid_d = dma_gnt && !dir_q;
    out_data_d  = out_data_q;
    if (dma_gnt && !dir_q) begin
      out_data_d = memReadData;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      dir_q       <= 1'b0;
      base_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      starve_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      base_q      <= base_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - self-checking bench for data_mem_arbiter
module tb_data_mem_arbiter;
  localparam int SL = 4;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpuRead, cpuWrite;
  logic [31:0]   cpuAddress, cpuWriteData, cpuReadData;
  logic          cpuStall;
  logic          dmaStart, dmaDir;
  logic [31:0]   dmaBase;
  logic [LW-1:0] dmaLen;
  logic [31:0]   dmaInData;
  logic          dmaInValid, dmaInReady;
  logic [31:0]   dmaOutData;
  logic          dmaOutValid, dmaBusy, dmaDone;
  logic          memRead, memWrite;
  logic [31:0]   memAddress, memWriteData, memReadData;

  logic [31:0]   mem [256];
  logic [31:0]   ref_mem [256];
  logic          poke_en;
  logic [7:0]    poke_addr;
  logic [31:0]   poke_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign memReadData = mem[memAddress[7:0]];
  always @(posedge clk) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    else if (memWrite) mem[memAddress[7:0]] <= memWriteData;
  end

  data_mem_arbiter #(.STARVE_LIMIT(SL), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .cpuRead(cpuRead), .cpuWrite(cpuWrite), .cpuAddress(cpuAddress),
    .cpuWriteData(cpuWriteData), .cpuReadData(cpuReadData), .cpuStall(cpuStall),
    .dmaStart(dmaStart), .dmaDir(dmaDir), .dmaBase(dmaBase), .dmaLen(dmaLen),
    .dmaInData(dmaInData), .dmaInValid(dmaInValid), .dmaInReady(dmaInReady),
    .dmaOutData(dmaOutData), .dmaOutValid(dmaOutValid), .dmaBusy(dmaBusy), .dmaDone(dmaDone),
    .memRead(memRead), .memWrite(memWrite), .memAddress(memAddress),
    .memWriteData(memWriteData), .memReadData(memReadData)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_in();
    cpuRead = 0; cpuWrite = 0; cpuAddress = 0; cpuWriteData = 0;
    dmaStart = 0; dmaDir = 0; dmaBase = 0; dmaLen = 0; dmaInData = 0; dmaInValid = 0;
    poke_en = 0; poke_addr = 0; poke_data = 0;
  endtask

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    poke_en = 1; poke_addr = a; poke_data = d;
    step();
    poke_en = 0;
  endtask

  task automatic start(input logic dir, input logic [31:0] base, input logic [LW-1:0] len);
    dmaStart = 1; dmaDir = dir; dmaBase = base; dmaLen = len;
    step();
    dmaStart = 0; dmaDir = 0;
  endtask

  task automatic test_reset();
    idle_in();
    rst = 0; cpuRead = 1; cpuAddress = 32'h55;
    step(); settle();
    total++;
    if ({dmaBusy, dmaDone, dmaOutValid, cpuStall} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000", {dmaBusy, dmaDone, dmaOutValid, cpuStall});
    end
    total++;
    if (dmaOutData !== 32'h0) begin
      bad++; $display("FAIL reset_outdata got=%h exp=0", dmaOutData);
    end
    total++;
    if ({memRead, memWrite, memAddress} !== {1'b1, 1'b0, 32'h55}) begin
      bad++; $display("FAIL reset_passthrough got=%b%b %h exp=10 00000055", memRead, memWrite, memAddress);
    end
    cpuRead = 0;
    rst = 1;
    step();
  endtask

  task automatic test_read_burst();
    logic [31:0] got[$];
    int first, last, done_at;
    logic stall;
    first = -1; last = -1; done_at = -1; stall = 0;
    poke(8'h10, 32'hAAAA_0001);
    poke(8'h11, 32'hBBBB_0002);
    poke(8'h12, 32'hCCCC_0003);
    start(0, 32'h10, 3);
    for (int i = 0; i < 8; i++) begin
      settle();
      if (dmaOutValid) begin
        got.push_back(dmaOutData);
        if (first < 0) first = i;
        last = i;
      end
      if (dmaDone) done_at = i;
      if (cpuStall) stall = 1;
      step();
    end
    total++;
    if (got.size() != 3 || first != 1 || last != 3) begin
      bad++; $display("FAIL rd_valid_run got=n%0d first%0d last%0d exp=n3 first1 last3", got.size(), first, last);
    end
    if (got.size() == 3) begin
      total++;
      if ({got[0], got[1], got[2]} !== {32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003}) begin
        bad++; $display("FAIL rd_data got=%h %h %h exp=aaaa0001 bbbb0002 cccc0003", got[0], got[1], got[2]);
      end
    end
    total++;
    if (done_at != 3) begin
      bad++; $display("FAIL rd_done got=%0d exp=3", done_at);
    end
    total++;
    if (stall !== 1'b0) begin
      bad++; $display("FAIL rd_stall got=%b exp=0", stall);
    end
  endtask

  task automatic test_write_gaps();
    int pat[6] = '{1, 0, 1, 1, 0, 1};
    logic [31:0] exp_w[4] = '{32'hD000_0000, 32'hD000_0002, 32'hD000_0003, 32'hD000_0005};
    logic exp_rdy;
    int done_at;
    done_at = -1;
    start(1, 32'h20, 4);
    for (int k = 0; k < 8; k++) begin
      dmaInValid = (k < 6) ? (pat[k] == 1) : 1'b0;
      dmaInData  = 32'hD000_0000 + 32'(k);
      exp_rdy    = dmaInValid;
      settle();
      total++;
      if (dmaInReady !== exp_rdy) begin
        bad++; $display("FAIL wr_ready_%0d got=%b exp=%b", k, dmaInReady, exp_rdy);
      end
      if (dmaDone) done_at = k;
      step();
    end
    dmaInValid = 0;
    total++;
    if (done_at != 6) begin
      bad++; $display("FAIL wr_done got=%0d exp=6", done_at);
    end
    for (int j = 0; j < 4; j++) begin
      total++;
      if (mem[8'h20 + 8'(j)] !== exp_w[j]) begin
        bad++; $display("FAIL wr_mem_%0d got=%h exp=%h", j, mem[8'h20 + 8'(j)], exp_w[j]);
      end
    end
  endtask

  task automatic test_starvation();
    logic exp_stall;
    logic [31:0] exp_addr;
    cpuRead = 1; cpuAddress = 32'h80;
    start(0, 32'h30, 2);
    for (int c = 1; c <= 12; c++) begin
      exp_stall = (c == 5) || (c == 10);
      exp_addr  = (c == 5) ? 32'h30 : (c == 10) ? 32'h31 : 32'h80;
      settle();
      total++;
      if (cpuStall !== exp_stall || memAddress !== exp_addr) begin
        bad++; $display("FAIL starve_c%0d got=%b %h exp=%b %h", c, cpuStall, memAddress, exp_stall, exp_addr);
      end
      if (c == 11) begin
        total++;
        if (dmaDone !== 1'b1) begin
          bad++; $display("FAIL starve_done got=%b exp=1", dmaDone);
        end
      end
      step();
    end
    cpuRead = 0;
  endtask

  task automatic test_len_zero();
    dmaInValid = 1; dmaInData = 32'h1234_5678;
    start(1, 32'h70, 0);
    settle();
    total++;
    if ({dmaDone, memRead, memWrite, dmaInReady} !== 4'b1000) begin
      bad++; $display("FAIL len0_done got=%b exp=1000", {dmaDone, memRead, memWrite, dmaInReady});
    end
    step(); settle();
    total++;
    if ({dmaBusy, dmaDone} !== 2'b00) begin
      bad++; $display("FAIL len0_idle got=%b exp=00", {dmaBusy, dmaDone});
    end
    dmaInValid = 0;
  endtask

  task automatic test_wrap();
    start(0, 32'hFFFF_FFFF, 2);
    settle();
    total++;
    if ({memRead, memAddress} !== {1'b1, 32'hFFFF_FFFF}) begin
      bad++; $display("FAIL wrap_first got=%b %h exp=1 ffffffff", memRead, memAddress);
    end
    step(); settle();
    total++;
    if ({memRead, memAddress} !== {1'b1, 32'h0}) begin
      bad++; $display("FAIL wrap_second got=%b %h exp=1 00000000", memRead, memAddress);
    end
    step(); settle();
    total++;
    if (dmaDone !== 1'b1) begin
      bad++; $display("FAIL wrap_done got=%b exp=1", dmaDone);
    end
    step();
  endtask

  task automatic test_start_during_burst();
    cpuRead = 1; cpuAddress = 32'h84;
    start(0, 32'h40, 3);
    for (int c = 1; c <= 4; c++) begin
      dmaStart = (c == 2); dmaDir = (c == 2); dmaBase = 32'h99; dmaLen = 1;
      settle();
      total++;
      if ({cpuStall, memAddress} !== {1'b0, 32'h84}) begin
        bad++; $display("FAIL busy_start_c%0d got=%b %h exp=0 00000084", c, cpuStall, memAddress);
      end
      step();
    end
    dmaStart = 0; dmaDir = 0;
    settle();
    total++;
    if ({cpuStall, memAddress} !== {1'b1, 32'h40}) begin
      bad++; $display("FAIL busy_start_forced got=%b %h exp=1 00000040", cpuStall, memAddress);
    end
    step();
    cpuRead = 0;
    for (int c = 6; c <= 7; c++) begin
      settle();
      total++;
      if ({memRead, memWrite, memAddress} !== {2'b10, 32'h40 + 32'(c - 5)}) begin
        bad++; $display("FAIL busy_start_word_c%0d got=%b%b %h exp=10 %h", c, memRead, memWrite, memAddress, 32'h40 + 32'(c - 5));
      end
      step();
    end
    dmaStart = 1; dmaBase = 32'h99; dmaLen = 1;
    settle();
    total++;
    if (dmaDone !== 1'b1) begin
      bad++; $display("FAIL busy_start_done got=%b exp=1", dmaDone);
    end
    step();
    dmaStart = 0;
    settle();
    total++;
    if (dmaBusy !== 1'b0) begin
      bad++; $display("FAIL done_start_ignored got=%b exp=0", dmaBusy);
    end
    step();
  endtask

  task automatic test_reset_mid_burst();
    start(0, 32'h50, 5);
    settle(); step();
    settle(); step();
    total++;
    if (dmaOutValid !== 1'b1) begin
      bad++; $display("FAIL midrst_pre got=%b exp=1", dmaOutValid);
    end
    rst = 0;
    settle();
    total++;
    if ({dmaBusy, dmaOutValid} !== 2'b00) begin
      bad++; $display("FAIL midrst_abort got=%b exp=00", {dmaBusy, dmaOutValid});
    end
    step(); settle();
    total++;
    if ({dmaBusy, dmaDone} !== 2'b00) begin
      bad++; $display("FAIL midrst_nodone got=%b exp=00", {dmaBusy, dmaDone});
    end
    rst = 1;
    step();
    start(0, 32'h60, 2);
    settle();
    total++;
    if (memAddress !== 32'h60) begin
      bad++; $display("FAIL midrst_restart0 got=%h exp=00000060", memAddress);
    end
    step(); settle();
    total++;
    if (memAddress !== 32'h61) begin
      bad++; $display("FAIL midrst_restart1 got=%h exp=00000061", memAddress);
    end
    step(); step();
  endtask

  task automatic test_random();
    int r, ph, m_starve, nmis;
    logic cpu_req, want, dma_g, e_rd, e_wr, m_dir, pend_v, n_pend_v;
    logic [31:0] e_addr, e_wd, m_base, m_idx, m_len, pend_d, n_pend_d;
    for (int a = 0; a < 256; a++) poke(8'(a), $urandom);
    for (int a = 0; a < 256; a++) ref_mem[a] = mem[a];
    ph = 0; m_starve = 0; pend_v = 0; pend_d = 0;
    m_dir = 0; m_base = 0; m_idx = 0; m_len = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc < 1460) begin
        r = $urandom_range(0, 3);
        cpuRead  = (r == 1);
        cpuWrite = (r == 2);
        dmaStart = ($urandom_range(0, 5) == 0);
        dmaInValid = ($urandom_range(0, 1) == 1);
      end else begin
        cpuRead = 0; cpuWrite = 0; dmaStart = 0; dmaInValid = 1;
      end
      cpuAddress   = $urandom_range(0, 255);
      cpuWriteData = $urandom;
      dmaDir       = ($urandom_range(0, 1) == 1);
      dmaBase      = $urandom_range(0, 240);
      dmaLen       = LW'($urandom_range(0, 7));
      dmaInData    = $urandom;
      settle();
      cpu_req = cpuRead || cpuWrite;
      want    = (ph == 1) && (!m_dir || dmaInValid);
      dma_g   = want && !(cpu_req && (m_starve < SL));
      e_addr  = dma_g ? (m_base + m_idx) : cpuAddress;
      e_rd    = dma_g ? !m_dir : cpuRead;
      e_wr    = dma_g ? m_dir : cpuWrite;
      e_wd    = dma_g ? dmaInData : cpuWriteData;
      total++;
      if ({memRead, memWrite, memAddress, memWriteData} !== {e_rd, e_wr, e_addr, e_wd}) begin
        bad++; $display("FAIL rnd_mem_c%0d got=%b%b %h %h exp=%b%b %h %h", cyc,
                        memRead, memWrite, memAddress, memWriteData, e_rd, e_wr, e_addr, e_wd);
      end
      total++;
      if ({cpuStall, dmaInReady, dmaBusy, dmaDone} !== {cpu_req && dma_g, dma_g && m_dir, ph != 0, ph == 2}) begin
        bad++; $display("FAIL rnd_ctl_c%0d got=%b exp=%b", cyc, {cpuStall, dmaInReady, dmaBusy, dmaDone},
                        {cpu_req && dma_g, dma_g && m_dir, ph != 0, ph == 2});
      end
      total++;
      if (dmaOutValid !== pend_v) begin
        bad++; $display("FAIL rnd_ovalid_c%0d got=%b exp=%b", cyc, dmaOutValid, pend_v);
      end
      if (pend_v) begin
        total++;
        if (dmaOutData !== pend_d) begin
          bad++; $display("FAIL rnd_odata_c%0d got=%h exp=%h", cyc, dmaOutData, pend_d);
        end
      end
      total++;
      if (cpuReadData !== ref_mem[e_addr[7:0]]) begin
        bad++; $display("FAIL rnd_rdata_c%0d got=%h exp=%h", cyc, cpuReadData, ref_mem[e_addr[7:0]]);
      end
      n_pend_v = dma_g && !m_dir;
      n_pend_d = ref_mem[e_addr[7:0]];
      if (dma_g && m_dir) ref_mem[e_addr[7:0]] = dmaInData;
      else if (!dma_g && cpuWrite) ref_mem[cpuAddress[7:0]] = cpuWriteData;
      if (ph == 0) m_starve = 0;
      else if (dma_g) m_starve = 0;
      else if (want && m_starve < SL) m_starve++;
      case (ph)
        0: if (dmaStart) begin
             m_dir = dmaDir; m_base = dmaBase; m_len = 32'(dmaLen); m_idx = 0;
             ph = (dmaLen == 0) ? 2 : 1;
           end
        1: if (dma_g) begin
             m_idx = m_idx + 1;
             if (m_idx == m_len) ph = 2;
           end
        default: ph = 0;
      endcase
      pend_v = n_pend_v;
      pend_d = n_pend_d;
      step();
    end
    idle_in();
    total++;
    if (ph != 0 || dmaBusy !== 1'b0) begin
      bad++; $display("FAIL rnd_drain got=busy%b phase%0d exp=busy0 phase0", dmaBusy, ph);
    end
    nmis = 0;
    for (int a = 0; a < 256; a++) if (mem[a] !== ref_mem[a]) nmis++;
    total++;
    if (nmis != 0) begin
      bad++; $display("FAIL rnd_memory got=%0d differing words exp=0", nmis);
    end
  endtask

  initial begin
    idle_in();
    rst = 0;
    test_reset();
    test_read_burst();
    test_write_gaps();
    test_starvation();
    test_len_zero();
    test_wrap();
    test_start_during_burst();
    test_reset_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
